// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader for the instruction memory.
// Packs bytes into 32-bit words, writes them to imem, holds cpu_rst until done.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   start           one-cycle pulse, begins a load from IDLE/DONE/ERR
//   in_valid/ready  byte-stream handshake, in_data carries the byte
//   imem_we/addr/wdata  instruction-memory write port (one strobe per word)
//   cpu_rst         active-high pipeline reset, low only in DONE
//   busy/done/error load status (error only in checksum builds)
//
// Build option: define IMEM_LOADER_CHECKSUM_EN to append and verify an XOR
// checksum byte after the last word. Without it error is tied low.

module imem_loader #(
   parameter int unsigned       ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              error
);

   // LAST covers the cycle where the final word is being written in
   // non-checksum builds; DONE follows it so cpu_rst never drops early.
   typedef enum logic [2:0] {
      IDLE,
      COUNT,
      DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK,
      ERR,
`else
      LAST,
`endif
      DONE
   } state_t;

   state_t            state;
   state_t            stateNxt;
   logic              accept;
   logic              wordEnd;
   logic              lastWord;
   logic              startLoad;
   logic [1:0]        byteIdx;
   logic [23:0]       shiftReg;
   logic [8:0]        wordsLeft;
   logic [ADDR_W-1:0] writeAddr;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   assign accept   = in_valid && in_ready;
   assign wordEnd  = accept && (state == DATA) && (byteIdx == 2'd3);
   assign lastWord = (wordsLeft == 9'd1);

   // COUNT is only ever entered through an accepted start.
   assign startLoad = (stateNxt == COUNT) && (state != COUNT);

   always_comb begin
      stateNxt = state;
      unique case (state)
         IDLE, DONE: begin
            if (start) stateNxt = COUNT;
         end
         COUNT: begin
            if (accept) stateNxt = DATA;
         end
         DATA: begin
            if (wordEnd && lastWord) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               stateNxt = CHECK;
`else
               stateNxt = LAST;
`endif
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHECK: begin
            if (accept) stateNxt = (in_data == csum) ? DONE : ERR;
         end
         ERR: begin
            if (start) stateNxt = COUNT;
         end
`else
         LAST: begin
            stateNxt = DONE;
         end
`endif
         default: stateNxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= BASE_ADDR;
         imem_wdata <= 32'h0;
         cpu_rst    <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         byteIdx    <= 2'd0;
         shiftReg   <= 24'h0;
         wordsLeft  <= 9'd0;
         writeAddr  <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum       <= 8'h00;
         error      <= 1'b0;
`endif
      end else begin
         state   <= stateNxt;
         done    <= (stateNxt == DONE);
         cpu_rst <= (stateNxt != DONE);
         imem_we <= wordEnd;
`ifdef IMEM_LOADER_CHECKSUM_EN
         error    <= (stateNxt == ERR);
         in_ready <= (stateNxt == COUNT) || (stateNxt == DATA) ||
                     (stateNxt == CHECK);
         busy     <= (stateNxt == COUNT) || (stateNxt == DATA) ||
                     (stateNxt == CHECK);
`else
         in_ready <= (stateNxt == COUNT) || (stateNxt == DATA);
         busy     <= (stateNxt == COUNT) || (stateNxt == DATA) ||
                     (stateNxt == LAST);
`endif

         if (startLoad) begin
            byteIdx   <= 2'd0;
            writeAddr <= BASE_ADDR;
            imem_addr <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum      <= 8'h00;
`endif
         end

`ifdef IMEM_LOADER_CHECKSUM_EN
         if (accept && ((state == COUNT) || (state == DATA))) begin
            csum <= csum ^ in_data;
         end
`endif

         // A count of zero stands for a full 256-word image.
         if (accept && (state == COUNT)) begin
            wordsLeft <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
         end

         // Bytes arrive LSB first, so shift in from the top.
         if (accept && (state == DATA)) begin
            byteIdx  <= byteIdx + 2'd1;
            shiftReg <= {in_data, shiftReg[23:8]};
         end

         // Address/data are registered with the strobe and then held,
         // while writeAddr already points at the next slot.
         if (wordEnd) begin
            imem_wdata <= {in_data, shiftReg};
            imem_addr  <= writeAddr;
            writeAddr  <= writeAddr + 1'b1;
            wordsLeft  <= wordsLeft - 9'd1;
         end
      end
   end

`ifndef IMEM_LOADER_CHECKSUM_EN
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader.
// Cycle table for the basic load, hand sequences, randomized frames.

`timescale 1ns/1ps

module tb_imem_loader;

   localparam int unsigned AW   = 8;
   localparam logic [7:0]  BASE = 8'h00;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CS = 1'b1;
`else
   localparam bit CS = 1'b0;
`endif
   localparam logic [45:0] RSTVEC =
      {1'b0, 1'b0, BASE, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0};

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_rst;
   logic        busy;
   logic        done;
   logic        error;

   imem_loader #(
      .ADDR_W    (AW),
      .BASE_ADDR (BASE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst    (cpu_rst),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   int vecs = 0;
   int miscompares = 0;

   logic [7:0]  wrAddr[$];
   logic [31:0] wrData[$];
   logic [31:0] words[$];

   always @(negedge clk) begin
      if (imem_we) begin
         wrAddr.push_back(imem_addr);
         wrData.push_back(imem_wdata);
      end
   end

   typedef struct {
      logic        st;
      logic        vld;
      logic [7:0]  dat;
      logic [45:0] exp;
   } vec_t;

   vec_t tbl[13];

   function automatic logic [45:0] outVec();
      return {in_ready, imem_we, imem_addr, imem_wdata,
              cpu_rst, busy, done, error};
   endfunction

   function automatic logic [45:0] ex(logic rdy, logic we, logic [7:0] a,
                                      logic [31:0] d, logic cr, logic bs,
                                      logic dn);
      return {rdy, we, a, d, cr, bs, dn, 1'b0};
   endfunction

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Presents one byte, optionally preceded by idle gaps and stray starts.
   task automatic sendByte(input logic [7:0] b, input int gapPct,
                           input int stPct);
      int guard;
      guard = 0;
      while (gapPct > 0 && $urandom_range(99, 0) < gapPct && guard < 20) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         start    = (stPct > 0) && ($urandom_range(99, 0) < stPct);
         @(negedge clk);
         guard++;
      end
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      guard    = 0;
      while (!in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("byte accepted", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Sends the frame held in words[] and checks the resulting writes.
   task automatic runFrame(input string tag, input int gapPct,
                           input int stPct, input bit doStart);
      logic [7:0] cs8;
      logic [7:0] b;
      int n;
      int waited;
      n = words.size();
      wrAddr.delete();
      wrData.delete();
      if (doStart) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      cs8 = 8'(n);
      sendByte(8'(n), gapPct, stPct);
      foreach (words[k]) begin
         for (int j = 0; j < 4; j++) begin
            b   = 8'(words[k] >> (8 * j));
            cs8 = cs8 ^ b;
            sendByte(b, gapPct, stPct);
         end
      end
      if (CS) sendByte(cs8, gapPct, stPct);
      waited = 0;
      while (!done && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      check({tag, " status"}, {done, cpu_rst, error, busy, in_ready},
            5'b10000);
      check({tag, " write count"}, wrAddr.size(), n);
      for (int k = 0; k < n && k < wrAddr.size(); k++) begin
         check($sformatf("%s write %0d", tag, k), {wrAddr[k], wrData[k]},
               {BASE + 8'(k), words[k]});
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // Basic 2-word load, cycle by cycle. Checksum of 02,13,93,10 is 92.
      tbl[0]  = '{1'b1, 1'b0, 8'h00, ex(1, 0, 0, 32'h0, 1, 1, 0)};
      tbl[1]  = '{1'b0, 1'b1, 8'h02, ex(1, 0, 0, 32'h0, 1, 1, 0)};
      tbl[2]  = '{1'b0, 1'b1, 8'h13, ex(1, 0, 0, 32'h0, 1, 1, 0)};
      tbl[3]  = '{1'b0, 1'b1, 8'h00, ex(1, 0, 0, 32'h0, 1, 1, 0)};
      tbl[4]  = '{1'b0, 1'b1, 8'h00, ex(1, 0, 0, 32'h0, 1, 1, 0)};
      tbl[5]  = '{1'b0, 1'b1, 8'h00, ex(1, 1, 0, 32'h13, 1, 1, 0)};
      tbl[6]  = '{1'b0, 1'b1, 8'h93, ex(1, 0, 0, 32'h13, 1, 1, 0)};
      tbl[7]  = '{1'b0, 1'b1, 8'h00, ex(1, 0, 0, 32'h13, 1, 1, 0)};
      tbl[8]  = '{1'b0, 1'b1, 8'h10, ex(1, 0, 0, 32'h13, 1, 1, 0)};
      tbl[9]  = '{1'b0, 1'b1, 8'h00,
                  ex(CS, 1, 1, 32'h00100093, 1, 1, 0)};
      tbl[10] = '{1'b0, CS, CS ? 8'h92 : 8'h00,
                  ex(0, 0, 1, 32'h00100093, 0, 0, 1)};
      tbl[11] = '{1'b0, 1'b1, 8'h55, ex(0, 0, 1, 32'h00100093, 0, 0, 1)};
      tbl[12] = '{1'b0, 1'b1, 8'hAA, ex(0, 0, 1, 32'h00100093, 0, 0, 1)};

      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset values", outVec(), RSTVEC);
      rst = 1'b1;
      @(negedge clk);
      check("idle after reset", outVec(), RSTVEC);

      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         @(negedge clk);
         check("idle ignores byte", {in_ready, busy, done, imem_we, cpu_rst},
               5'b00001);
      end
      in_valid = 1'b0;
      check("idle no writes", wrAddr.size(), 0);

      foreach (tbl[i]) begin
         start    = tbl[i].st;
         in_valid = tbl[i].vld;
         in_data  = tbl[i].dat;
         @(negedge clk);
         check($sformatf("table row %0d", i), outVec(), tbl[i].exp);
      end
      start    = 1'b0;
      in_valid = 1'b0;
      check("table write count", wrAddr.size(), 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
      wrAddr.delete();
      wrData.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      sendByte(8'h02, 0, 0);
      sendByte(8'h13, 0, 0);
      sendByte(8'h00, 0, 0);
      sendByte(8'h00, 0, 0);
      sendByte(8'h00, 0, 0);
      sendByte(8'h93, 0, 0);
      sendByte(8'h00, 0, 0);
      sendByte(8'h10, 0, 0);
      sendByte(8'h00, 0, 0);
      sendByte(8'h00, 0, 0);
      check("bad csum status", {done, error, cpu_rst, busy, in_ready},
            5'b01100);
      check("bad csum writes", wrAddr.size(), 2);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("error held", {error, cpu_rst, in_ready}, 3'b110);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start clears error", {error, done, in_ready, busy, cpu_rst},
            5'b00111);
      words = {32'h00000013, 32'h00100093};
      runFrame("after error", 0, 0, 1'b0);
`endif

      words = {$urandom};
      runFrame("gappy 1-word", 60, 0, 1'b1);

      words.delete();
      for (int k = 0; k < 256; k++) words.push_back(32'(k));
      runFrame("256 words", 0, 0, 1'b1);
      check("256 last addr", (wrAddr.size() > 0) ? wrAddr[$] : 8'h00, 8'hFF);

      words = {$urandom, $urandom, $urandom};
      wrAddr.delete();
      wrData.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      sendByte(8'd3, 0, 0);
      for (int j = 0; j < 6; j++) begin
         sendByte(8'(words[j / 4] >> (8 * (j % 4))), 0, 0);
      end
      check("pre-reset writes", wrAddr.size(), 1);
      rst = 1'b0;
      @(negedge clk);
      check("mid-frame reset", outVec(), RSTVEC);
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("no write after reset", wrAddr.size(), 1);
      check("idle after mid reset", {in_ready, busy, done, cpu_rst}, 4'b0001);
      runFrame("post-reset load", 0, 0, 1'b1);

      for (int r = 0; r < 15; r++) begin
         words.delete();
         repeat ($urandom_range(8, 1)) words.push_back($urandom);
         runFrame($sformatf("random %0d", r), 40, 15, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs,
               miscompares);
      $finish;
   end

endmodule
